// File: rtl/tristate_bus_pkg.sv
// ---------------------------------------------------------------------------
// tristate_bus_pkg
//
// Shared types and constants for the tristate bus controller slice.
//   state_e : bus-owner FSM states (IDLE, DRIVE, TURN)
//   BEAT_W  : width of the DRIVE beat counter (holds MAX_BURST up to 15)
//   TURN_W  : width of the turnaround counter (holds TURN_CYC up to 3)
// ---------------------------------------------------------------------------
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    localparam int BEAT_W = 4;
    localparam int TURN_W = 2;

endpackage

// File: rtl/tristate_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// tristate_bus_ctrl_if
//
// Bundles the requester-side and bus-side signals of the controller.
//   req        : per-requester bus request (level)
//   data_in    : per-requester data, slice i belongs to requester i
//   grant      : one-hot registered grant, or all zero
//   bus_en     : registered enable for the external tristate buffers
//   bus_data   : data presented to the tristate buffers
//   bus_in     : readback of the resolved shared bus
//   contention : sticky contention flag
//
// Handshake: a requester raises req and holds it for as long as it wants
// the bus; grant[i] high is the acknowledgement and means requester i owns
// the bus in that cycle. Ownership ends when the requester drops req or the
// burst limit is hit; after that the bus idles for the turnaround period and
// requests seen during turnaround have no effect until IDLE is reached.
//
// Modports: master = controller side, slave = requester/bus side.
// ---------------------------------------------------------------------------
interface tristate_bus_ctrl_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    logic                    bus_en;
    logic [DATA_W-1:0]       bus_data;
    logic [DATA_W-1:0]       bus_in;
    logic                    contention;

    modport master (
        input  req,
        input  data_in,
        input  bus_in,
        output grant,
        output bus_en,
        output bus_data,
        output contention
    );

    modport slave (
        output req,
        output data_in,
        output bus_in,
        input  grant,
        input  bus_en,
        input  bus_data,
        input  contention
    );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Combinational round-robin winner selection. The search starts at
// (last_owner + 1) mod N_REQ and wraps, so the previous owner has the lowest
// priority.
//   req        : in  N_REQ  request vector
//   last_owner : in  IDX_W  index of the most recent owner
//   winner     : out N_REQ  one-hot winner, zero when no request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] winner
);

    always_comb begin
        logic           found;
        int unsigned    pos;
        logic [IDX_W-1:0] pos_idx;
        winner  = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos     = (int'(last_owner) + k) % N_REQ;
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                winner[pos_idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_buffer.sv
// ---------------------------------------------------------------------------
// tristate_buffer
//
// Single tristate driver onto a shared net; one instance per requester.
//   en : in  1  drive enable
//   d  : in  W  data to drive
//   y  : out W  shared net, high impedance when en is low
// ---------------------------------------------------------------------------
module tristate_buffer #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] d,
    output tri   [W-1:0] y
);

    assign y = en ? d : {W{1'bz}};

endmodule

// File: rtl/tristate_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tristate_bus_ctrl
//
// Arbitrates a shared tristate bus among N_REQ requesters. A round-robin
// winner is granted for up to MAX_BURST cycles, then the bus idles for
// TURN_CYC cycles before the next owner is picked.
//
// Ports:
//   clk   : in   sole clock, rising edge
//   rst   : in   synchronous reset, active high
//   bus   : tristate_bus_ctrl_if.master (req, data_in, bus_in in;
//           grant, bus_en, bus_data, contention out)
//   state : out  current FSM state, for observation
//
// Build option: CONTENTION_CHECK_EN -- when defined, compares bus_in with
// bus_data on every edge where bus_en was high throughout the previous cycle
// and sets the sticky contention flag on a difference. When undefined,
// contention is tied low and bus_in is ignored.
// ---------------------------------------------------------------------------
module tristate_bus_ctrl
    import tristate_bus_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst,
    tristate_bus_ctrl_if.master bus,
    output state_e              state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               bus_en_q, bus_en_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [TURN_W-1:0]  turn_q, turn_d;

    logic [N_REQ-1:0]   winner;
    logic [IDX_W-1:0]   winner_idx;
    logic               owner_req;
    logic               burst_done;
    logic [DATA_W-1:0]  data_arr [N_REQ];

    // Unpack the flat data vector so the owner slice can be indexed directly.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = bus.data_in[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                winner_idx = IDX_W'(i);
            end
        end
    end

    assign owner_req  = bus.req[owner_q];
    assign burst_done = (beat_q == BEAT_W'(MAX_BURST));

    // Next-state and next-output logic. grant and bus_en are registered so
    // they change together on the edge that enters or leaves DRIVE.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        bus_en_d     = bus_en_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        turn_d       = turn_q;

        case (state_q)
            IDLE: begin
                grant_d  = '0;
                bus_en_d = 1'b0;
                if (|bus.req) begin
                    state_d      = DRIVE;
                    grant_d      = winner;
                    bus_en_d     = 1'b1;
                    owner_d      = winner_idx;
                    // Updating here (not at DRIVE exit) keeps the rotation
                    // moving even when the same set keeps requesting.
                    last_owner_d = winner_idx;
                    beat_d       = BEAT_W'(1);
                end
            end

            DRIVE: begin
                // Request drop and burst limit in the same cycle collapse
                // into one exit; both conditions lead to the same branch.
                if (!owner_req || burst_done) begin
                    state_d  = TURN;
                    grant_d  = '0;
                    bus_en_d = 1'b0;
                    beat_d   = '0;
                    turn_d   = TURN_W'(1);
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end

            TURN: begin
                grant_d  = '0;
                bus_en_d = 1'b0;
                if (turn_q == TURN_W'(TURN_CYC)) begin
                    state_d = IDLE;
                    turn_d  = '0;
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                bus_en_d = 1'b0;
                beat_d   = '0;
                turn_d   = '0;
            end
        endcase
    end

    // Reset drops bus_en immediately with no turnaround, and points
    // last_owner at the highest index so requester 0 is favoured first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            bus_en_q     <= 1'b0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            beat_q       <= '0;
            turn_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            bus_en_q     <= bus_en_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
            turn_q       <= turn_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.bus_en   = bus_en_q;
    // Only the owner slice reaches the bus; other requesters' data is
    // never selected.
    assign bus.bus_data = bus_en_q ? data_arr[owner_q] : '0;
    assign state        = state_q;

`ifdef CONTENTION_CHECK_EN
    logic contention_q;

    // bus_en_q high at an edge means it was high for the whole cycle that
    // just ended, so the readback had a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            contention_q <= 1'b0;
        end else if (bus_en_q && (bus.bus_in != bus.bus_data)) begin
            contention_q <= 1'b1;
        end
    end

    assign bus.contention = contention_q;
`else
    logic unused_bus_in;

    assign unused_bus_in  = ^bus.bus_in;
    assign bus.contention = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tristate_bus_ctrl
//
// Directed bench for tristate_bus_ctrl. Main instance uses defaults
// (N_REQ=4, DATA_W=8, MAX_BURST=4, TURN_CYC=1) with a tristate buffer per
// requester on a shared net feeding bus_in. A second instance with
// MAX_BURST=2, TURN_CYC=2 covers the simultaneous drop/limit exit and a
// longer turnaround.
// ---------------------------------------------------------------------------
module tb_tristate_bus_ctrl;
    import tristate_bus_pkg::*;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUTs and bus ----------------
    tristate_bus_ctrl_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus  ();
    tristate_bus_ctrl_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus2 ();

    state_e state;
    state_e state2;

    tri   [DATA_W-1:0] shared_bus;
    logic              force_zero;
    logic [DATA_W-1:0] data_v [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_buf
        tristate_buffer #(.W(DATA_W)) u_buf (
            .en (bus.grant[i]),
            .d  (bus.data_in[i*DATA_W +: DATA_W]),
            .y  (shared_bus)
        );
    end

    assign bus.bus_in  = force_zero ? '0 : shared_bus;
    assign bus2.bus_in = bus2.bus_data;

    tristate_bus_ctrl #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(4), .TURN_CYC(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
    );

    tristate_bus_ctrl #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(2), .TURN_CYC(2)
    ) dut2 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus2),
        .state (state2)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        bus.data_in = {data_v[3], data_v[2], data_v[1], data_v[0]};
    endtask

    task automatic chk1(input string tag, input logic [3:0] e_grant,
                        input logic e_en, input logic [7:0] e_data,
                        input state_e e_state);
        check({tag, ".grant"},    32'(bus.grant),    32'(e_grant));
        check({tag, ".bus_en"},   32'(bus.bus_en),   32'(e_en));
        check({tag, ".bus_data"}, 32'(bus.bus_data), 32'(e_data));
        check({tag, ".state"},    32'(state),        32'(e_state));
    endtask

    task automatic chk2(input string tag, input logic [3:0] e_grant,
                        input logic e_en, input logic [7:0] e_data,
                        input state_e e_state);
        check({tag, ".grant"},    32'(bus2.grant),    32'(e_grant));
        check({tag, ".bus_en"},   32'(bus2.bus_en),   32'(e_en));
        check({tag, ".bus_data"}, 32'(bus2.bus_data), 32'(e_data));
        check({tag, ".state"},    32'(state2),        32'(e_state));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] exp_grant;
        logic       exp_cont;
        int         idx;

`ifdef CONTENTION_CHECK_EN
        exp_cont = 1'b1;
`else
        exp_cont = 1'b0;
`endif

        rst         = 1'b1;
        force_zero  = 1'b0;
        bus.req     = '0;
        bus2.req    = '0;
        data_v[0]   = 8'hA5;
        data_v[1]   = 8'h11;
        data_v[2]   = 8'h22;
        data_v[3]   = 8'h33;
        set_data();
        bus2.data_in = {8'h44, 8'h33, 8'h22, 8'h11};

        step();
        step();
        chk1("reset", 4'b0000, 1'b0, 8'h00, IDLE);
        check("reset.contention", 32'(bus.contention), 32'd0);
        chk2("reset2", 4'b0000, 1'b0, 8'h00, IDLE);

        // First grant one cycle after req is sampled in IDLE.
        rst     = 1'b0;
        bus.req = 4'b0001;
        step();
        chk1("first_grant", 4'b0001, 1'b1, 8'hA5, DRIVE);
        check("first_grant.readback", 32'(shared_bus), 32'hA5);

        // Non-owner data must not reach the bus; owner data follows at once.
        data_v[1] = 8'hEE;
        set_data();
        #1;
        check("nonowner_data", 32'(bus.bus_data), 32'hA5);
        data_v[0] = 8'h3C;
        set_data();
        #1;
        check("owner_data", 32'(bus.bus_data), 32'h3C);

        // Held request: 4 DRIVE beats, 1 TURN, 1 IDLE, then re-grant.
        for (int b = 2; b <= 4; b++) begin
            step();
            chk1("burst", 4'b0001, 1'b1, 8'h3C, DRIVE);
        end
        step();
        chk1("burst_turn", 4'b0000, 1'b0, 8'h00, TURN);
        step();
        chk1("burst_idle", 4'b0000, 1'b0, 8'h00, IDLE);
        step();
        chk1("regrant", 4'b0001, 1'b1, 8'h3C, DRIVE);

        // Owner drops request: exit to TURN, then IDLE stays idle.
        bus.req = 4'b0000;
        step();
        chk1("drop_turn", 4'b0000, 1'b0, 8'h00, TURN);
        step();
        chk1("drop_idle", 4'b0000, 1'b0, 8'h00, IDLE);
        step();
        chk1("no_req_idle", 4'b0000, 1'b0, 8'h00, IDLE);

        // last_owner is 0, so requester 1 wins next.
        bus.req = 4'b1111;
        step();
        chk1("rr_after_0", 4'b0010, 1'b1, 8'hEE, DRIVE);

        // Reset mid-DRIVE: bus released at that edge, no TURN.
        rst = 1'b1;
        step();
        chk1("rst_mid_drive", 4'b0000, 1'b0, 8'h00, IDLE);
        rst = 1'b0;

        // Full rotation 0001, 0010, 0100, 1000, 0001 with TURN/IDLE between.
        step();
        for (int g = 0; g < 5; g++) begin
            idx       = g % N_REQ;
            exp_grant = 4'b0001 << idx;
            for (int b = 0; b < 4; b++) begin
                chk1("rotate", exp_grant, 1'b1, data_v[idx], DRIVE);
                if (b == 0) begin
                    check("rotate.readback", 32'(shared_bus), 32'(data_v[idx]));
                end
                step();
            end
            chk1("rotate_turn", 4'b0000, 1'b0, 8'h00, TURN);
            step();
            chk1("rotate_idle", 4'b0000, 1'b0, 8'h00, IDLE);
            step();
        end

        // Contention: readback forced to 00 while 5A is driven.
        for (int i = 0; i < N_REQ; i++) begin
            data_v[i] = 8'h5A;
        end
        set_data();
        #1;
        check("pre_contention", 32'(bus.contention), 32'd0);
        force_zero = 1'b1;
        step();
        check("contention_set", 32'(bus.contention), 32'(exp_cont));
        force_zero = 1'b0;
        step();
        step();
        check("contention_sticky", 32'(bus.contention), 32'(exp_cont));
        bus.req = 4'b0000;
        rst     = 1'b1;
        step();
        check("contention_rst", 32'(bus.contention), 32'd0);
        rst = 1'b0;
        step();

        // Second instance: drop on beat 2 coincides with MAX_BURST=2.
        bus2.req = 4'b0001;
        step();
        chk2("mb2_beat1", 4'b0001, 1'b1, 8'h11, DRIVE);
        step();
        chk2("mb2_beat2", 4'b0001, 1'b1, 8'h11, DRIVE);
        bus2.req = 4'b0000;
        step();
        chk2("mb2_turn1", 4'b0000, 1'b0, 8'h00, TURN);
        // Request during TURN is ignored; TURN lasts two cycles.
        bus2.req = 4'b0010;
        step();
        chk2("mb2_turn2", 4'b0000, 1'b0, 8'h00, TURN);
        step();
        chk2("mb2_idle", 4'b0000, 1'b0, 8'h00, IDLE);
        step();
        chk2("mb2_next", 4'b0010, 1'b1, 8'h22, DRIVE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tristate_bus_ctrl.md
TRISTATE_BUS_CTRL -- requirements
Module: tristate_bus_ctrl

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, bus data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, maximum DRIVE cycles per grant (1..15).
REQ-004 The block SHALL have parameter TURN_CYC, default 1, bus-idle turnaround cycles between owners (1..3).
REQ-005 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 The block SHALL have port rst  input  1  synchronous reset, active high.
REQ-007 The block SHALL have port req  input  N_REQ  per-requester bus request, level.
REQ-008 The block SHALL have port data_in  input  N_REQ*DATA_W  per-requester data; slice i is requester i.
REQ-009 The block SHALL have port grant  output  N_REQ  one-hot registered grant, or all zero.
REQ-010 The block SHALL have port bus_en  output  1  registered enable to the downstream tristate buffers' enable.
REQ-011 The block SHALL have port bus_data  output  DATA_W  data to the downstream tristate buffers' data input.
REQ-012 The block SHALL have port bus_in  input  DATA_W  readback of the resolved shared bus.
REQ-013 The block SHALL have port contention  output  1  sticky contention error flag.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DRIVE and TURN.
REQ-015 In IDLE with any req bit high, the FSM SHALL pick a winner round-robin starting at (last_owner+1) mod N_REQ, then move to DRIVE on the next edge.
REQ-016 On entering DRIVE, grant and bus_en SHALL assert on the same edge: latency is 1 cycle from req sampled in IDLE.
REQ-017 In IDLE with req all zero, the FSM SHALL stay in IDLE with grant=0 and bus_en=0.
REQ-018 bus_data SHALL equal data_in[owner] combinationally while bus_en=1, and all zeros otherwise.
REQ-019 A 4-bit beat counter SHALL count DRIVE cycles from 1.
REQ-020 DRIVE SHALL exit to TURN when req[owner] is low or the count equals MAX_BURST, whichever comes first.
REQ-021 In TURN, grant=0 and bus_en=0 SHALL hold for exactly TURN_CYC cycles, then the FSM SHALL go to IDLE; req SHALL be ignored during TURN.
REQ-022 last_owner SHALL update on entry to DRIVE, which guarantees rotation among continuous requesters.
REQ-023 The owner dropping req and the count reaching MAX_BURST in the same cycle SHALL be handled as a single exit to TURN.
REQ-024 Changes on data_in of non-owners SHALL never affect bus_data.
REQ-025 bus_en and grant SHALL never be high in TURN or IDLE; grant SHALL never have more than one bit set.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL set state=IDLE, grant=0, bus_en=0, beat count=0, last_owner=N_REQ-1 (so requester 0 wins first) and contention=0.
REQ-027 rst asserted mid-DRIVE SHALL drop bus_en at that edge with no TURN period.

Configuration
REQ-028 With CONTENTION_CHECK_EN defined, the block SHALL set contention on any edge where bus_en was high for a full cycle and bus_in != bus_data; contention SHALL stay set until rst.
REQ-029 Without CONTENTION_CHECK_EN, contention SHALL be constant 0 and bus_in SHALL be unused.

Structure
REQ-030 Package tristate_bus_pkg SHALL hold the FSM state enum (IDLE/DRIVE/TURN) and the beat-counter width constant.
REQ-031 The round-robin winner selection SHALL be sub-module rr_arbiter (inputs req and last_owner; output one-hot winner).
REQ-032 The testbench SHALL instantiate tristate_buffer per requester on a shared wire for readback.

Verification
REQ-033 Reset release, req=4'b0001, data_in[0]=8'hA5 -> one cycle later grant=0001, bus_en=1, bus_data=A5.
REQ-034 req=4'b0001 held continuously, MAX_BURST=4, TURN_CYC=1 -> 4 DRIVE cycles, 1 idle cycle, 1 IDLE cycle, then re-grant to requester 0.
REQ-035 req=4'b1111 held -> grants rotate 0001, 0010, 0100, 1000, 0001, each separated by TURN.
REQ-036 Owner drops req after 2 beats while the count would reach MAX_BURST=2 -> single TURN; bus_en low the next cycle.
REQ-037 rst pulsed during DRIVE -> bus_en=0, grant=0 at that edge; after release, requester 0 has priority.
REQ-038 With CONTENTION_CHECK_EN and bus_in forced to 8'h00 while bus_data=8'h5A -> contention=1 and it stays 1 until rst.
